// File: rtl/hold_arbiter_pkg.sv
// Shared definitions for the hold_arbiter block.
//   arb_state_t   : arbiter FSM state (IDLE = no owner, GRANT = owner active)
//   ARB_N         : default requester count
//   ARB_HOLD_MAX  : default maximum consecutive grant cycles per ownership
//   onehot_to_idx : one-hot (or zero) vector, up to 32 bits wide, to a binary index
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N        = 8;
    localparam int ARB_HOLD_MAX = 15;

    // An all-zero input returns 0, so gnt_id reads 0 whenever no grant is active.
    function automatic int unsigned onehot_to_idx(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/hold_arbiter_if.sv
// Request/grant bundle between requesters and hold_arbiter.
//   req         : request vector, one bit per requester
//   gnt         : registered one-hot grant, or all zeros
//   gnt_valid   : gnt is non-zero
//   gnt_id      : binary index of the granted requester (0 when idle)
//   hold_expire : one-cycle pulse on the first cycle after a forced release
// Modports: master = requester side, slave = arbiter side.
interface hold_arbiter_if #(
    parameter int N = 8
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           hold_expire;

    modport master (output req, input gnt, gnt_valid, gnt_id, hold_expire);
    modport slave  (input req, output gnt, gnt_valid, gnt_id, hold_expire);
endinterface

// File: rtl/hold_arbiter_prio_onehot.sv
// prio_onehot: combinational highest-set-bit selector.
//   vec    : candidate vector
//   onehot : one-hot of the highest set bit of vec, zero when vec is zero
module prio_onehot #(
    parameter int N = 8
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] onehot
);
    // Ascending scan: the last (highest) set bit overwrites any earlier pick.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hold_arbiter.sv
// hold_arbiter: N-requester arbiter with a registered one-hot grant that is
// held while the owner keeps requesting and forcibly rotated after HOLD_MAX
// consecutive cycles so that competitors cannot starve.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : hold_arbiter_if.slave (req in; gnt, gnt_valid, gnt_id, hold_expire out)
// Optional feature macro: ARB_ROTATE_EN selects round-robin priority, where
// the search starts just below the most recent owner. Without it the
// priority is fixed with index N-1 highest. N must be a power of two, <= 32.
module hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int HOLD_MAX = ARB_HOLD_MAX
) (
    input  logic          clk,
    input  logic          reset,
    hold_arbiter_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(HOLD_MAX + 1);

    arb_state_t     state_q, state_d;
    logic [CW-1:0]  hold_cnt, hold_cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q;
    logic           expire_q, expire_d;

    logic [N-1:0]   cand;
    logic [N-1:0]   win;
    logic           owner_req;
    logic           expire_due;

    // A release (owner dropped req) never counts as an expiry, since
    // expire_due requires the owner to still be requesting.
    assign owner_req  = (state_q == GRANT) && bus.req[id_q];
    assign expire_due = owner_req && (hold_cnt == CW'(HOLD_MAX));

    always_comb begin
        cand = bus.req;
        if (expire_due) cand[id_q] = 1'b0;
    end

`ifdef ARB_ROTATE_EN
    logic [IDW-1:0] last_q;
    logic [N-1:0]   cand_rot, win_rot;

    // Rotate so that index last_q lands at bit 0 (lowest priority) and
    // last_q-1 lands at bit N-1 (highest), then undo the rotation.
    always_comb begin
        cand_rot = '0;
        win      = '0;
        for (int j = 0; j < N; j++) begin
            cand_rot[j]                        = cand[IDW'(j + int'(last_q))];
            win[IDW'(j + int'(last_q))] = win_rot[j];
        end
    end

    prio_onehot #(.N(N)) u_prio (.vec(cand_rot), .onehot(win_rot));
`else
    prio_onehot #(.N(N)) u_prio (.vec(cand), .onehot(win));
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt;
        gnt_d      = gnt_q;
        expire_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = GRANT;
                    gnt_d      = win;
                    hold_cnt_d = CW'(1);
                end
            end
            GRANT: begin
                if (owner_req && !expire_due) begin
                    hold_cnt_d = hold_cnt + CW'(1);
                end else if (!owner_req) begin
                    // Owner's bit is already clear in cand: switch with no bubble.
                    if (|win) begin
                        gnt_d      = win;
                        hold_cnt_d = CW'(1);
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                    end
                end else begin
                    // Forced release; a lone owner is simply re-granted.
                    hold_cnt_d = CW'(1);
                    expire_d   = 1'b1;
                    if (|win) gnt_d = win;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        endcase
        id_d = IDW'(onehot_to_idx(32'(gnt_d)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_cnt <= hold_cnt_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            valid_q  <= |gnt_d;
            expire_q <= expire_d;
        end
    end

`ifdef ARB_ROTATE_EN
    // hold_cnt_d == 1 marks the first cycle of every new ownership.
    always_ff @(posedge clk) begin
        if (reset)
            last_q <= '0;
        else if (state_d == GRANT && hold_cnt_d == CW'(1))
            last_q <= id_d;
    end
`endif

    assign bus.gnt         = gnt_q;
    assign bus.gnt_valid   = valid_q;
    assign bus.gnt_id      = id_q;
    assign bus.hold_expire = expire_q;
endmodule

// File: tb/tb_hold_arbiter.sv
// Self-checking bench for hold_arbiter. Two instances (HOLD_MAX 15 and 3)
// share req/reset; each is compared against a behavioural model of the
// ownership rules, plus fixed expectations for the directed scenarios.
module tb_hold_arbiter;
`ifdef ARB_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hold_arbiter_if #(.N(8)) if15 ();
    hold_arbiter_if #(.N(8)) if3 ();
    assign if15.req = req;
    assign if3.req  = req;

    hold_arbiter #(.N(8), .HOLD_MAX(15)) dut15 (.clk(clk), .reset(rst), .bus(if15.slave));
    hold_arbiter #(.N(8), .HOLD_MAX(3))  dut3  (.clk(clk), .reset(rst), .bus(if3.slave));

    // Packed observation {hold_expire, gnt_id, gnt_valid, gnt}
    logic [12:0] obs [2];
    assign obs[0] = {if15.hold_expire, if15.gnt_id, if15.gnt_valid, if15.gnt};
    assign obs[1] = {if3.hold_expire, if3.gnt_id, if3.gnt_valid, if3.gnt};

    // Model: owner index (-1 = none), cycles owned so far, last owner.
    int   hm    [2] = '{15, 3};
    int   owner [2] = '{-1, -1};
    int   cnt   [2] = '{0, 0};
    int   last  [2] = '{0, 0};
    logic expire[2] = '{1'b0, 1'b0};

    function automatic int pick(input logic [7:0] c, input int lst);
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = ROT ? ((lst - k + 16) % 8) : (8 - k);
            if (((c >> idx) & 8'h01) != 8'h00) return idx;
        end
        return -1;
    endfunction

    function automatic logic [12:0] expv(input int d);
        logic [7:0] g;
        logic [2:0] id;
        g  = (owner[d] >= 0) ? (8'h01 << owner[d]) : 8'h00;
        id = (owner[d] >= 0) ? 3'(owner[d]) : 3'd0;
        return {expire[d], id, (owner[d] >= 0), g};
    endfunction

    task automatic model_step(input int d, input logic [7:0] r, input logic rs);
        int w;
        expire[d] = 1'b0;
        if (rs) begin
            owner[d] = -1; cnt[d] = 0; last[d] = 0;
            return;
        end
        if (owner[d] < 0) begin
            w = pick(r, last[d]);
            if (w >= 0) begin owner[d] = w; cnt[d] = 1; end
        end else if (((r >> owner[d]) & 8'h01) == 8'h00) begin
            w = pick(r, last[d]);
            if (w >= 0) begin owner[d] = w; cnt[d] = 1; end
            else begin owner[d] = -1; cnt[d] = 0; end
        end else if (cnt[d] < hm[d]) begin
            cnt[d]++;
        end else begin
            w = pick(r & ~(8'h01 << owner[d]), last[d]);
            if (w >= 0) owner[d] = w;
            cnt[d] = 1;
            expire[d] = 1'b1;
        end
        if (cnt[d] == 1) last[d] = owner[d];
    endtask

    // Drive at negedge, let the edge happen, advance the model, return at negedge.
    task automatic step(input logic [7:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(0, r, rs);
        model_step(1, r, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(8'hFF, 1'b1);
        step(8'h00, 1'b1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== 13'h0) $display("FAIL reset dut%0d got %h want 0", d, obs[d]);
            else passes++;
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== 13'h0) $display("FAIL idle dut%0d cyc %0d got %h want 0", d, i, obs[d]);
                else passes++;
            end
        end
    endtask

    task automatic test_switch();
        step(8'h24, 1'b0);
        checks++;
        if ({if15.gnt, if15.gnt_id} !== {8'h20, 3'd5})
            $display("FAIL switch_first got %h/%0d want 20/5", if15.gnt, if15.gnt_id);
        else passes++;
        step(8'h84, 1'b0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== {1'b0, 3'd7, 1'b1, 8'h80})
                $display("FAIL switch_nobubble dut%0d got %h want %h", d, obs[d], {1'b0, 3'd7, 1'b1, 8'h80});
            else passes++;
        end
        step(8'h00, 1'b0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== expv(d)) $display("FAIL switch_release dut%0d got %h want %h", d, obs[d], expv(d));
            else passes++;
        end
    endtask

    task automatic test_expire_81();
        for (int i = 1; i <= 32; i++) begin
            step(8'h81, 1'b0);
            if (i <= 15) begin
                checks++;
                if ({if15.gnt, if15.hold_expire} !== {8'h80, 1'b0})
                    $display("FAIL expire81_hold cyc %0d got %h/%b want 80/0", i, if15.gnt, if15.hold_expire);
                else passes++;
            end else if (i == 16) begin
                checks++;
                if ({if15.gnt, if15.hold_expire} !== {8'h01, 1'b1})
                    $display("FAIL expire81_switch got %h/%b want 01/1", if15.gnt, if15.hold_expire);
                else passes++;
            end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== expv(d)) $display("FAIL expire81 dut%0d cyc %0d got %h want %h", d, i, obs[d], expv(d));
                else passes++;
            end
        end
        step(8'h00, 1'b0);
    endtask

    task automatic test_single_hold();
        for (int i = 1; i <= 12; i++) begin
            step(8'h10, 1'b0);
            checks++;
            if ({if3.gnt, if3.hold_expire} !== {8'h10, (i > 1) && ((i - 1) % 3 == 0)})
                $display("FAIL single_hold cyc %0d got %h/%b want 10/%b", i, if3.gnt, if3.hold_expire,
                         (i > 1) && ((i - 1) % 3 == 0));
            else passes++;
            checks++;
            if (obs[0] !== expv(0)) $display("FAIL single_hold15 cyc %0d got %h want %h", i, obs[0], expv(0));
            else passes++;
        end
        step(8'h00, 1'b0);
    endtask

    task automatic test_no_preempt();
        step(8'h04, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(8'h84, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== {1'b0, 3'd2, 1'b1, 8'h04})
                    $display("FAIL no_preempt dut%0d cyc %0d got %h want %h", d, i, obs[d], {1'b0, 3'd2, 1'b1, 8'h04});
                else passes++;
            end
        end
        step(8'h80, 1'b0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== {1'b0, 3'd7, 1'b1, 8'h80})
                $display("FAIL no_preempt_release dut%0d got %h want %h", d, obs[d], {1'b0, 3'd7, 1'b1, 8'h80});
            else passes++;
        end
        step(8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b0);
        step(8'hFF, 1'b1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== 13'h0) $display("FAIL reset_mid dut%0d got %h want 0", d, obs[d]);
            else passes++;
        end
        step(8'hFF, 1'b0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== {1'b0, 3'd7, 1'b1, 8'h80})
                $display("FAIL reset_resume dut%0d got %h want %h", d, obs[d], {1'b0, 3'd7, 1'b1, 8'h80});
            else passes++;
        end
    endtask

    task automatic test_random();
        int n;
        n = 0;
        while (n < 400) begin
            logic [7:0] r;
            int len;
            r   = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                step(r, ($urandom_range(0, 60) == 0));
                n++;
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (obs[d] !== expv(d)) $display("FAIL random dut%0d cyc %0d got %h want %h", d, n, obs[d], expv(d));
                    else passes++;
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle();
        test_switch();
        test_expire_81();
        test_single_hold();
        test_no_preempt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
